// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared types and constants for the calculator frame
//               sequencer: FSM state encoding, frame byte slots, OP codes.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        RESULT  = 2'd2
    } state_t;

    // Position of each field within the 4-byte command frame
    localparam logic [1:0] IDX_OP = 2'd0;
    localparam logic [1:0] IDX_A  = 2'd1;
    localparam logic [1:0] IDX_B  = 2'd2;
    localparam logic [1:0] IDX_C  = 2'd3;

    // Calculator operation encodings carried in byte0[1:0]
    localparam logic [1:0] OP_ADD3 = 2'd0;  // A + B + C
    localparam logic [1:0] OP_BCMA = 2'd1;  // B + C - A
    localparam logic [1:0] OP_ACMB = 2'd2;  // A + C - B
    localparam logic [1:0] OP_ABMC = 2'd3;  // A + B - C

    // An OP byte is malformed when any of its reserved upper bits are set
    function automatic logic op_byte_err(input logic [7:0] op_byte);
        return |op_byte[7:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : calc_settle_timer
// Description : Loadable down-counter with a zero flag. Counts down while
//               enabled and parks at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_settle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load takes priority over decrement; the count never wraps below zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/calc_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calc_frame_sequencer
// Description : Front-end for the three-operand calculator. Collects a
//               4-byte command frame (OP, A, B, C), holds the operands on
//               the calculator inputs, waits a fixed settle time, captures
//               R / C_out and hands them downstream with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_frame_sequencer
    import calc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    // Frame byte stream
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    // Calculator operands
    output logic [7:0] calc_a,
    output logic [7:0] calc_b,
    output logic [7:0] calc_c,
    output logic [1:0] calc_op,
    // Calculator results
    input  logic [7:0] calc_r,
    input  logic [7:0] calc_cout,
    // Result stream
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_r,
    output logic [7:0] out_cout,
    output logic       out_err,
    output logic       busy
);

    // Settle counter starts one below the cycle count so that the capture
    // edge lands exactly SETTLE_CYCLES edges after the last byte.
    localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_byte_cnt;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_c;
    logic [1:0] r_op;
    logic       r_err;
    logic       r_out_valid;
    logic [7:0] r_out_r;
    logic [7:0] r_out_cout;

    logic       w_accept;
    logic       w_last_byte;
    logic       w_timer_zero;

    // A byte is taken only while collecting; in_ready depends on state alone
    assign w_accept    = (r_state == COLLECT) && in_valid;
    assign w_last_byte = w_accept && (r_byte_cnt == IDX_C);

    calc_settle_timer #(
        .WIDTH (4)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_last_byte),
        .i_load_val (c_settle_load),
        .i_dec      (r_state == SETTLE),
        .o_zero     (w_timer_zero)
    );

    // Frame collection, settle wait and result handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_byte_cnt  <= 2'd0;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_c         <= 8'd0;
            r_op        <= 2'd0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_r     <= 8'd0;
            r_out_cout  <= 8'd0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        case (r_byte_cnt)
                            IDX_OP: begin
                                r_op  <= in_data[1:0];
                                r_err <= op_byte_err(in_data);
                            end
                            IDX_A:  r_a <= in_data;
                            IDX_B:  r_b <= in_data;
                            IDX_C:  r_c <= in_data;
                        endcase
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte) begin
                            r_state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (w_timer_zero) begin
                        r_out_r     <= calc_r;
                        r_out_cout  <= calc_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= RESULT;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= COLLECT;
                    end
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == COLLECT);
    assign busy      = (r_state != COLLECT) || (r_byte_cnt != 2'd0);
    assign calc_a    = r_a;
    assign calc_b    = r_b;
    assign calc_c    = r_c;
    assign calc_op   = r_op;
    assign out_valid = r_out_valid;
    assign out_r     = r_out_r;
    assign out_cout  = r_out_cout;
    assign out_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_calc_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_frame_sequencer
// Description : Self-checking bench for calc_frame_sequencer with a
//               behavioural calculator attached to the operand outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_frame_sequencer;

    localparam int SETTLE_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] calc_a, calc_b, calc_c;
    logic [1:0] calc_op;
    logic [7:0] calc_r, calc_cout;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_r, out_cout;
    logic       out_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Calculator: R is the 8-bit wrapped result; C_out is the carry for the
    // sum and a borrow flag for the subtracting operations.
    function automatic logic [15:0] calc_model(input logic [7:0] a, b, c,
                                               input logic [1:0] op);
        int v;
        logic [7:0] co;
        case (op)
            2'd0:    v = int'(a) + int'(b) + int'(c);
            2'd1:    v = int'(b) + int'(c) - int'(a);
            2'd2:    v = int'(a) + int'(c) - int'(b);
            default: v = int'(a) + int'(b) - int'(c);
        endcase
        if (op == 2'd0) co = 8'(v >>> 8);
        else            co = (v < 0) ? 8'd1 : 8'd0;
        return {co, v[7:0]};
    endfunction

    assign {calc_cout, calc_r} = calc_model(calc_a, calc_b, calc_c, calc_op);

    calc_frame_sequencer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .calc_a    (calc_a),
        .calc_b    (calc_b),
        .calc_c    (calc_c),
        .calc_op   (calc_op),
        .calc_r    (calc_r),
        .calc_cout (calc_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_cout  (out_cout),
        .out_err   (out_err),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer the four frame bytes, optionally idling before each one
    task automatic send_frame(input logic [7:0] b0, b1, b2, b3,
                              input bit drop_valid, input int max_gap,
                              output int acc);
        logic [7:0] fr [4];
        fr[0] = b0; fr[1] = b1; fr[2] = b2; fr[3] = b3;
        for (int i = 0; i < 4; i++) begin
            int g;
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int k = 0; k < gap; k++) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = fr[i];
            g = 0;
            while (in_ready !== 1'b1 && g < 100) begin
                step();
                g++;
            end
            if (g >= 100) begin
                n_tests++; n_fail++;
                $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
            end
            step();
        end
        acc = cyc;
        if (drop_valid) in_valid = 1'b0;
    endtask

    // Wait for the result, checking operand stability and timing on the way
    task automatic wait_result(input logic [7:0] a, b, c, input logic [1:0] op,
                               input logic [7:0] er, ec, input logic ee,
                               input int acc, input string nm);
        int g;
        g = 0;
        while (out_valid !== 1'b1 && g < 100) begin
            n_tests++;
            if ({calc_a, calc_b, calc_c, calc_op} !== {a, b, c, op}) begin
                n_fail++;
                $display("FAIL %s operands: got %h/%h/%h/%0d required %h/%h/%h/%0d",
                         nm, calc_a, calc_b, calc_c, calc_op, a, b, c, op);
            end
            n_tests++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s settle_flags: busy=%b in_ready=%b required 1/0",
                         nm, busy, in_ready);
            end
            step();
            g++;
        end
        n_tests++;
        if (g >= 100) begin
            n_fail++;
            $display("FAIL %s result_timeout: out_valid=%b required 1", nm, out_valid);
        end else begin
            if (cyc - acc !== SETTLE_CYCLES) begin
                n_fail++;
                $display("FAIL %s latency: got %0d required %0d", nm, cyc - acc, SETTLE_CYCLES);
            end
            n_tests++;
            if (out_r !== er) begin
                n_fail++;
                $display("FAIL %s out_r: got %0d required %0d", nm, out_r, er);
            end
            n_tests++;
            if (out_cout !== ec) begin
                n_fail++;
                $display("FAIL %s out_cout: got %0d required %0d", nm, out_cout, ec);
            end
            n_tests++;
            if (out_err !== ee) begin
                n_fail++;
                $display("FAIL %s out_err: got %b required %b", nm, out_err, ee);
            end
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s in_ready_result: got %b required 0", nm, in_ready);
            end
        end
    endtask

    // Accept the pending result and confirm the handshake completes in one edge
    task automatic take_result(input string nm);
        out_ready = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s take: out_valid=%b in_ready=%b required 0/1",
                     nm, out_valid, in_ready);
        end
    endtask

    // Full frame: send, expect the spec-derived result, consume it
    task automatic run_frame(input logic [7:0] b0, a, b, c, input logic [7:0] er,
                             input string nm);
        int acc;
        logic [15:0] m;
        m = calc_model(a, b, c, b0[1:0]);
        send_frame(b0, a, b, c, 1'b1, 0, acc);
        wait_result(a, b, c, b0[1:0], er, m[15:8], (b0[7:2] != 6'd0), acc, nm);
        take_result(nm);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        n_tests++;
        if ({in_ready, out_valid, out_err, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 1000",
                     {in_ready, out_valid, out_err, busy});
        end
        n_tests++;
        if ({calc_a, calc_b, calc_c, calc_op, out_r, out_cout} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0",
                     {calc_a, calc_b, calc_c, calc_op, out_r, out_cout});
        end
    endtask

    task automatic test_basic();
        run_frame(8'h00, 8'd50, 8'd60, 8'd70, 8'd180, "add3");
    endtask

    task automatic test_ops();
        run_frame(8'h01, 8'd50, 8'd60, 8'd70, 8'd80, "bcma");
        run_frame(8'h02, 8'd50, 8'd60, 8'd70, 8'd60, "acmb");
        run_frame(8'h03, 8'd50, 8'd60, 8'd70, 8'd40, "abmc");
    endtask

    task automatic test_err();
        run_frame(8'hFD, 8'd1, 8'd2, 8'd3, 8'd4, "op_err");
    endtask

    task automatic test_backpressure();
        int acc;
        out_ready = 1'b0;
        send_frame(8'h00, 8'd50, 8'd60, 8'd70, 1'b1, 0, acc);
        wait_result(8'd50, 8'd60, 8'd70, 2'd0, 8'd180, 8'd0, 1'b0, acc, "bp");
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_r !== 8'd180 || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold: out_valid=%b out_r=%0d in_ready=%b busy=%b required 1/180/0/1",
                         out_valid, out_r, in_ready, busy);
            end
        end
        in_valid = 1'b0;
        take_result("bp");
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_consume: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_data  = 8'h03;
        step();
        in_data  = 8'hAA;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if ({in_ready, out_valid, busy, out_err} !== 4'b1000 || calc_a !== 8'd0 || calc_op !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_state: flags=%b calc_a=%h calc_op=%0d required 1000/00/0",
                     {in_ready, out_valid, busy, out_err}, calc_a, calc_op);
        end
        run_frame(8'h00, 8'd1, 8'd1, 8'd1, 8'd3, "midrst");
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_stray: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] fa [6];
        logic [7:0] fb [6];
        logic [7:0] fc [6];
        logic [7:0] fo [6];
        int acc;
        int results;
        results = 0;
        out_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            logic [15:0] m;
            fo[f] = 8'($urandom_range(3, 0));
            fa[f] = 8'($urandom); fb[f] = 8'($urandom); fc[f] = 8'($urandom);
            m = calc_model(fa[f], fb[f], fc[f], fo[f][1:0]);
            send_frame(fo[f], fa[f], fb[f], fc[f], 1'b0, 0, acc);
            wait_result(fa[f], fb[f], fc[f], fo[f][1:0], m[7:0], m[15:8], 1'b0, acc, "b2b");
            if (out_valid === 1'b1) results++;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid === 1'b1) results++;
        end
        n_tests++;
        if (results !== 6 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: results=%0d busy=%b required 6/0", results, busy);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 20; f++) begin
            logic [7:0] b0, a, b, c;
            logic [15:0] m;
            int acc;
            int dly;
            b0 = ($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'($urandom_range(3, 0));
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            m = calc_model(a, b, c, b0[1:0]);
            out_ready = 1'b0;
            send_frame(b0, a, b, c, 1'b1, 2, acc);
            wait_result(a, b, c, b0[1:0], m[7:0], m[15:8], (b0 >= 8'd4), acc, "rand");
            dly = int'($urandom_range(3, 0));
            for (int k = 0; k < dly; k++) step();
            n_tests++;
            if (out_valid !== 1'b1 || out_r !== m[7:0]) begin
                n_fail++;
                $display("FAIL rand_hold: out_valid=%b out_r=%0d required 1/%0d",
                         out_valid, out_r, m[7:0]);
            end
            take_result("rand");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ops();
        test_err();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/calc_frame_sequencer.md
Name: calc_frame_sequencer

Overview:
- Upstream/front-end stage for the three-operand calculator (8-bit A, B, C; 2-bit OP; 8-bit R and C_out).
- Collects a 4-byte command frame from a byte stream with a valid/ready handshake and holds the operands stable on the calculator inputs.
- Waits a fixed settle time, captures the calculator's R and C_out, and presents them downstream with a valid/ready handshake.
- Turns the purely combinational calculator into a clocked, flow-controlled pipeline stage.

Parameters:
- SETTLE_CYCLES, 2: cycles from last-byte acceptance to result capture; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a valid byte
- in_ready  output  1  block accepts a byte this cycle
- in_data  input  8  frame byte
- calc_a  output  8  operand A to calculator
- calc_b  output  8  operand B to calculator
- calc_c  output  8  operand C to calculator
- calc_op  output  2  OP to calculator
- calc_r  input  8  calculator result R
- calc_cout  input  8  calculator C_out
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_r  output  8  captured R
- out_cout  output  8  captured C_out
- out_err  output  1  frame had nonzero OP byte bits [7:2]
- busy  output  1  high whenever state != COLLECT or byte count != 0

Behaviour:
- Interface is fixed as decided: one clock (clk); reset (rst) is synchronous and active-high.
- Frame format, in order:
  - byte0: OP, using bits [1:0]; bits [7:2] must be 0.
  - byte1: A.
  - byte2: B.
  - byte3: C.
- A byte transfers on a rising edge with in_valid && in_ready.
- States:
  - COLLECT: in_ready=1. A 2-bit byte counter selects the destination register; it increments per transfer and wraps 3->0. The byte3 transfer loads the settle counter with SETTLE_CYCLES-1 and moves to SETTLE.
  - SETTLE: in_ready=0. The counter decrements each cycle. At the edge where the counter is 0: capture calc_r into out_r and calc_cout into out_cout, set out_valid=1, move to RESULT.
  - RESULT: in_ready=0, out_valid=1. out_r, out_cout and out_err are held stable. The edge with out_ready=1 clears out_valid and returns to COLLECT; in_ready=1 in the following cycle.
- Latency: last byte accepted at edge k -> out_valid high after edge k+SETTLE_CYCLES. With the default, the result is visible 2 cycles after C is accepted.
- Operand registers:
  - calc_a/b/c/op are driven directly from registers loaded as each byte arrives.
  - They stay unchanged from byte3 acceptance until the next frame's byte of the same slot arrives.
  - They are therefore stable for the full SETTLE window.
- out_err:
  - Computed from byte0[7:2] != 0 when byte0 is accepted and held with the frame.
  - It does not block computation; calc_op still uses byte0[1:0].
- in_valid during SETTLE/RESULT is ignored; no byte is consumed and no data is lost upstream.
- out_ready during COLLECT/SETTLE has no effect.
- Reset values: in_ready=1, out_valid=0, out_err=0, busy=0, and all data outputs, counters and operand registers = 0; state=COLLECT.
- Reset mid-operation (any state, including mid-frame or while out_valid=1): partial frame discarded, pending result dropped, all registers return to reset values at that edge.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Shared package calc_pkg:
  - State enum {COLLECT, SETTLE, RESULT}.
  - Byte-index constants IDX_OP=0, IDX_A=1, IDX_B=2, IDX_C=3.
  - OP encodings OP_ADD3=0, OP_BCMA=1, OP_ACMB=2, OP_ABMC=3.
- One natural sub-module: calc_settle_timer, a loadable down-counter with a zero flag used by the SETTLE state.
- The calculator itself is instantiated by the parent, not inside this block.

Test Plan:
- Frame {0x00, 50, 60, 70} with a bench calculator model (R = A+B+C, B+C-A, A+C-B, A+B-C mod 256 per OP) -> out_r=180, out_err=0; out_valid rises 2 cycles after byte3 is accepted.
- Frames with OP=1, 2, 3, same operands -> out_r = 80, 60, 40 respectively; calc_a/b/c constant throughout SETTLE.
- Hold out_ready=0 for 10 cycles with in_valid=1 -> out_valid and out_r held, in_ready=0, no bytes consumed; releasing out_ready gives exactly one transfer, then in_ready=1 the next cycle.
- Byte0=0xFD, A=1, B=2, C=3 -> calc_op=1, out_r=4, out_err=1.
- rst asserted after 2 bytes of a frame, then full frame {0x00, 1, 1, 1} -> no stray result; out_r=3 from the new frame only.
- Back-to-back frames with in_valid always 1 and out_ready always 1 -> one result per frame, none dropped or duplicated; byte counter wraps correctly.
